// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame, device ACK check.
// Data line updates 3 clk after a device clock fall; tx_ready low (tx_valid ignored) from accept until done/timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_FRAME,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_bad_q, ack_bad_d;
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             fall;

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2_data_oe = data_oe_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        byte_d     = byte_q;
        parity_d   = parity_q;
        data_oe_d  = data_oe_q;
        ack_bad_d  = ack_bad_q;
        done       = 1'b0;
        ack_err    = 1'b0;
        timeout    = 1'b0;
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_data_in;
        dat_s2_d   = dat_s1_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    byte_d   = tx_data;
                    parity_d = ~^tx_data;
                    cnt_d    = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = S_FRAME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FRAME: begin
                // bitcnt_q counts falls already seen; the bit for this fall is indexed by it
                if (fall) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q < 4'd8) begin
                        data_oe_d = ~byte_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_bad_d = dat_s2_q;
                    state_d   = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done    = 1'b1;
                    ack_err = ack_bad_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Watchdog on device clocking; an abort wins over a same-cycle completion
        if (state_q == S_FRAME || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
            if (fall) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                timeout   = 1'b1;
                done      = 1'b0;
                ack_err   = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ack_bad_q  <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            data_oe_q  <= data_oe_d;
            ack_bad_q  <= ack_bad_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device that clocks frames and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int SET  = 12;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_n = 0, ackerr_n = 0, stray_n = 0, tout_n = 0;
    int last_done_cyc = 0, tout_cyc = 0, acc_cyc = 0, fall_cyc = 0;
    int total = 0, passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_n <= done_n + 1;
            last_done_cyc <= cyc;
            if (ack_err) ackerr_n <= ackerr_n + 1;
        end else if (ack_err) begin
            stray_n <= stray_n + 1;
        end
        if (timeout) begin
            tout_n <= tout_n + 1;
            tout_cyc <= cyc;
        end
        if (tx_valid && tx_ready) acc_cyc <= cyc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = d[k];
            ones += int'(d[k]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic measure_req(input string tag);
        int w = 0, n_inh = 0, n_req = 0;
        while (!ps2_clk_oe && w < 200) begin tick(); w++; end
        while (ps2_clk_oe && !ps2_data_oe && n_inh < 10 * INH) begin tick(); n_inh++; end
        while (ps2_clk_oe && ps2_data_oe && n_req < 10 * SET) begin tick(); n_req++; end
        chk({tag, "_inhibit_len"}, n_inh, INH);
        chk({tag, "_setup_len"}, n_req, SET);
        chk({tag, "_frame_start_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device clocking: line sampled mid-high before each fall; ACK driven before the 11th fall
    task automatic dev_clock(input int nclk, input bit give_ack, output logic [10:0] bits);
        bits = '0;
        for (int i = 0; i < nclk; i++) begin
            repeat (HALF / 2) tick();
            bits[i] = ps2_data_in;
            repeat (HALF / 2) tick();
            if (i == 10 && give_ack) begin
                dev_data_low = 1'b1;
                repeat (3) tick();
            end
            dev_clk_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
        end
        if (give_ack && nclk == 11) begin
            repeat (HALF) tick();
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int d0);
        int w = 0;
        while (done_n == d0 && w < 200) begin tick(); w++; end
        chk({tag, "_done_count"}, done_n - d0, 1);
        chk({tag, "_done_width"}, done, 1'b0);
    endtask

    task automatic start(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 2000) begin tick(); w++; end
        tx_data = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit give_ack, input string tag);
        int d0 = done_n, a0 = ackerr_n;
        logic [10:0] got;
        start(d);
        chk({tag, "_busy"}, busy, 1'b1);
        measure_req(tag);
        dev_clock(11, give_ack, got);
        chk({tag, "_bits"}, got, frame_bits(d));
        wait_done(tag, d0);
        chk({tag, "_ack_err"}, ackerr_n - a0, give_ack ? 0 : 1);
        chk({tag, "_ready"}, tx_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] got;
        logic [7:0]  rb;
        int          d0, t0, w, el;

        #2;
        chk("rst_ready_busy", {tx_ready, busy}, 2'b10);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("rst_pulses", {done, ack_err, timeout}, 3'b000);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Directed commands, then random bytes
        send(8'hED, 1'b1, "ed");
        send(8'hF4, 1'b1, "f4");
        send(8'h00, 1'b1, "zero");
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b1, "rand");
        end

        // Missing ACK
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b0, "noack");

        // Device stops clocking after 4 falls
        d0 = done_n;
        t0 = tout_n;
        start(8'hA5);
        measure_req("to");
        dev_clock(4, 1'b0, got);
        chk("to_first_bits", got[3:0], 4'(frame_bits(8'hA5)));
        w = 0;
        while (tout_n == t0 && w < TO + 60) begin tick(); w++; end
        el = tout_cyc - fall_cyc;
        chk("to_window", (el >= TO && el <= TO + 4), 1'b1);
        chk("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        repeat (3) tick();
        chk("to_count", tout_n - t0, 1);
        chk("to_no_done", done_n - d0, 0);
        chk("to_ready", tx_ready, 1'b1);

        // Reset during the frame while data_oe shows bit 4 of 0xED (0 -> driven low)
        start(8'hED);
        measure_req("rst");
        dev_clock(5, 1'b0, got);
        chk("rst_pre_data_oe", ps2_data_oe, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("rst_async_ready", tx_ready, 1'b1);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        send(8'hED, 1'b1, "after_rst");

        // tx_valid held through a transfer with different data
        d0 = done_n;
        tx_data = 8'hED;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'h5A;
        measure_req("hold1");
        dev_clock(11, 1'b1, got);
        chk("hold1_bits", got, frame_bits(8'hED));
        wait_done("hold1", d0);
        chk("hold1_ready", tx_ready, 1'b1);
        d0 = done_n;
        measure_req("hold2");
        tx_valid = 1'b0;
        chk("hold2_accept_after_done", acc_cyc - last_done_cyc, 1);
        dev_clock(11, 1'b1, got);
        chk("hold2_bits", got, frame_bits(8'h5A));
        wait_done("hold2", d0);
        chk("stray_ack_err", stray_n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
